// File: rtl/vending_controller.sv
// Vending controller: serial coin receiver, credit register, vend handshake
// and serialised change return in one clocked block.
module vending_controller #(
    parameter int                             N_PRODUCTS  = 4,
    parameter int                             SEL_W       = 2,
    parameter int                             CREDIT_W    = 8,
    parameter int                             MAX_CREDIT  = 200,
    parameter logic [N_PRODUCTS*CREDIT_W-1:0] PRICES      = {8'd75, 8'd60, 8'd35, 8'd20},
    parameter bit                             AUTO_CHANGE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                serialIn,
    input  logic [SEL_W-1:0]    product,
    input  logic                buy,
    input  logic                coin_return,
    input  logic                vend_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_valid,
    output logic [SEL_W-1:0]    vend_item,
    output logic                error,
    output logic                coin_reject,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic [1:0]          ctrl_state_o,
    output logic [1:0]          rx_state_o
);

    // Handshake: vend_valid rises with vend_item stable and both hold until a
    // cycle with vend_ack=1; that cycle completes the transfer.

    typedef enum logic [1:0] {RX_IDLE, RX_B1, RX_B0} rx_state_t;
    typedef enum logic [1:0] {IDLE, VEND, CHANGE} ctrl_state_t;

    localparam logic [CREDIT_W:0] MAX_W = (CREDIT_W+1)'(MAX_CREDIT);

    rx_state_t          rx_q;
    ctrl_state_t        ctrl_q;
    logic               code_hi_q;
    logic [CREDIT_W-1:0] credit_q;
    logic               vend_valid_q;
    logic [SEL_W-1:0]   vend_item_q;
    logic               error_q;
    logic               reject_q;

    logic                coin_done;
    logic [CREDIT_W-1:0] coin_val;
    logic                prod_ok;
    logic [CREDIT_W-1:0] price;
    logic                buy_ok;
    logic [CREDIT_W-1:0] base_credit;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] chg_val;
    logic [1:0]          chg_code;

    always_comb begin
        coin_done = (rx_q == RX_B0);
        case ({code_hi_q, serialIn})
            2'b00:   coin_val = CREDIT_W'(1);
            2'b01:   coin_val = CREDIT_W'(5);
            2'b10:   coin_val = CREDIT_W'(10);
            default: coin_val = CREDIT_W'(25);
        endcase

        prod_ok = 1'b0;
        price   = '0;
        for (int i = 0; i < N_PRODUCTS; i++) begin
            if (product == SEL_W'(i)) begin
                prod_ok = 1'b1;
                price   = PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end

        // A purchase is judged on pre-coin credit; a coin landing on the same
        // edge is then added to what remains, and overflow is checked on that.
        buy_ok      = (ctrl_q == IDLE) && buy && prod_ok && (credit_q >= price);
        base_credit = buy_ok ? (credit_q - price) : credit_q;
        coin_sum    = {1'b0, base_credit} + {1'b0, coin_val};
        coin_ok     = coin_done && (ctrl_q != CHANGE) && (coin_sum <= MAX_W);

        if (credit_q >= CREDIT_W'(25)) begin
            chg_val = CREDIT_W'(25); chg_code = 2'b11;
        end else if (credit_q >= CREDIT_W'(10)) begin
            chg_val = CREDIT_W'(10); chg_code = 2'b10;
        end else if (credit_q >= CREDIT_W'(5)) begin
            chg_val = CREDIT_W'(5);  chg_code = 2'b01;
        end else begin
            chg_val = CREDIT_W'(1);  chg_code = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q         <= RX_IDLE;
            ctrl_q       <= IDLE;
            code_hi_q    <= 1'b0;
            credit_q     <= '0;
            vend_valid_q <= 1'b0;
            vend_item_q  <= '0;
            error_q      <= 1'b0;
            reject_q     <= 1'b0;
        end else begin
            error_q  <= 1'b0;
            reject_q <= coin_done && !coin_ok;

            case (rx_q)
                RX_IDLE: if (serialIn) rx_q <= RX_B1;
                RX_B1: begin
                    code_hi_q <= serialIn;
                    rx_q      <= RX_B0;
                end
                default: rx_q <= RX_IDLE;
            endcase

            credit_q <= coin_ok ? coin_sum[CREDIT_W-1:0] : base_credit;

            case (ctrl_q)
                IDLE: begin
                    if (buy) begin
                        if (buy_ok) begin
                            vend_valid_q <= 1'b1;
                            vend_item_q  <= product;
                            ctrl_q       <= VEND;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end else if (coin_return && credit_q != '0) begin
                        ctrl_q <= CHANGE;
                    end
                end
                VEND: begin
                    if (vend_ack) begin
                        vend_valid_q <= 1'b0;
                        ctrl_q <= (AUTO_CHANGE && credit_q != '0) ? CHANGE : IDLE;
                    end
                end
                CHANGE: begin
                    if (credit_q != '0) credit_q <= credit_q - chg_val;
                    else                ctrl_q   <= IDLE;
                end
                default: ctrl_q <= IDLE;
            endcase
        end
    end

    // Change is decoded from the registered credit so the coin shown in a
    // cycle is exactly the amount removed on that cycle's closing edge.
    assign change_valid = (ctrl_q == CHANGE) && (credit_q != '0);
    assign change_coin  = change_valid ? chg_code : 2'b00;

    assign credit       = credit_q;
    assign vend_valid   = vend_valid_q;
    assign vend_item    = vend_item_q;
    assign error        = error_q;
    assign coin_reject  = reject_q;
    assign ctrl_state_o = ctrl_q;
    assign rx_state_o   = rx_q;

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller: vector table for the main flows,
// hand sequences for overflow, coin/buy overlap, manual change and reset.
module tb_vending_controller;

    localparam int SEL_W = 3;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_VEND = 2'd1, ST_CHANGE = 2'd2;

    logic clk = 1'b0;
    logic reset, serial_in, buy, coin_return, vend_ack;
    logic [SEL_W-1:0] product;

    logic [7:0] a_credit, m_credit;
    logic a_vv, m_vv, a_err, m_err, a_rej, m_rej, a_cv, m_cv;
    logic [SEL_W-1:0] a_item, m_item;
    logic [1:0] a_coin, m_coin, a_st, m_st, a_rx, m_rx;

    always #5 clk = ~clk;

    vending_controller #(.SEL_W(SEL_W), .AUTO_CHANGE(1'b1)) dut_a (
        .clk(clk), .reset(reset), .serialIn(serial_in), .product(product),
        .buy(buy), .coin_return(coin_return), .vend_ack(vend_ack),
        .credit(a_credit), .vend_valid(a_vv), .vend_item(a_item), .error(a_err),
        .coin_reject(a_rej), .change_valid(a_cv), .change_coin(a_coin),
        .ctrl_state_o(a_st), .rx_state_o(a_rx));

    vending_controller #(.SEL_W(SEL_W), .AUTO_CHANGE(1'b0)) dut_m (
        .clk(clk), .reset(reset), .serialIn(serial_in), .product(product),
        .buy(buy), .coin_return(coin_return), .vend_ack(vend_ack),
        .credit(m_credit), .vend_valid(m_vv), .vend_item(m_item), .error(m_err),
        .coin_reject(m_rej), .change_valid(m_cv), .change_coin(m_coin),
        .ctrl_state_o(m_st), .rx_state_o(m_rx));

    typedef struct packed {
        logic rst; logic ser; logic [2:0] prod; logic buy; logic cret; logic ack;
        logic [7:0] credit; logic vv; logic [2:0] item; logic err; logic rej;
        logic cv; logic [1:0] coin; logic [1:0] st;
    } vec_t;

    vec_t vecs[$];
    logic [1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    function automatic vec_t mk(input logic rst, ser, input logic [2:0] prod,
                                input logic b, c, a, input logic [7:0] cr,
                                input logic vv, input logic [2:0] item,
                                input logic err, rej, cv, input logic [1:0] coin, st);
        vec_t v;
        v.rst = rst; v.ser = ser; v.prod = prod; v.buy = b; v.cret = c; v.ack = a;
        v.credit = cr; v.vv = vv; v.item = item; v.err = err; v.rej = rej;
        v.cv = cv; v.coin = coin; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic r, s, input logic [2:0] p, input logic b, c, a);
        reset = r; serial_in = s; product = p; buy = b; coin_return = c; vend_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask

    // Three-cycle coin frame; optionally a buy rides on the completing cycle.
    task automatic send_coin(input logic [1:0] code, input logic b, input logic [2:0] p);
        logic [1:0] cc;
        cc = code;
        step(0, 1, 0, 0, 0, 0);
        step(0, cc[1], 0, 0, 0, 0);
        step(0, cc[0], p, b, 0, 0);
    endtask

    initial begin
        int budget;
        reset = 1; serial_in = 0; buy = 0; coin_return = 0; vend_ack = 0; product = '0;

        // Deposit four quarters, buy the 60c product, slow ack, auto change 25/10/5
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0,ST_IDLE));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0,1,0,0,0,0, 8'(25*k),0,0,0,0,0,0,ST_IDLE));
            vecs.push_back(mk(0,1,0,0,0,0, 8'(25*k),0,0,0,0,0,0,ST_IDLE));
            vecs.push_back(mk(0,1,0,0,0,0, 8'(25*(k+1)),0,0,0,0,0,0,ST_IDLE));
        end
        vecs.push_back(mk(0,0,2,1,0,0, 40,1,2,0,0,0,0,ST_VEND));
        vecs.push_back(mk(0,0,0,1,1,0, 40,1,2,0,0,0,0,ST_VEND));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(0,0,0,0,0,0, 40,1,2,0,0,0,0,ST_VEND));
        vecs.push_back(mk(0,0,0,0,0,1, 40,0,2,0,0,1,2'b11,ST_CHANGE));
        vecs.push_back(mk(0,0,0,1,0,0, 15,0,2,0,0,1,2'b10,ST_CHANGE));
        vecs.push_back(mk(0,0,0,0,0,0,  5,0,2,0,0,1,2'b01,ST_CHANGE));
        vecs.push_back(mk(0,0,0,0,0,0,  0,0,2,0,0,0,0,ST_CHANGE));
        vecs.push_back(mk(0,0,0,0,0,0,  0,0,2,0,0,0,0,ST_IDLE));
        // 30c credit: too-poor buy, invalid product, then buy beats coin_return
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0,ST_IDLE));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0,0,0,ST_IDLE));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0,0,0,ST_IDLE));
        vecs.push_back(mk(0,1,0,0,0,0, 25,0,0,0,0,0,0,ST_IDLE));
        vecs.push_back(mk(0,1,0,0,0,0, 25,0,0,0,0,0,0,ST_IDLE));
        vecs.push_back(mk(0,0,0,0,0,0, 25,0,0,0,0,0,0,ST_IDLE));
        vecs.push_back(mk(0,1,0,0,0,0, 30,0,0,0,0,0,0,ST_IDLE));
        vecs.push_back(mk(0,0,3,1,0,0, 30,0,0,1,0,0,0,ST_IDLE));
        vecs.push_back(mk(0,0,0,0,0,0, 30,0,0,0,0,0,0,ST_IDLE));
        vecs.push_back(mk(0,0,5,1,0,0, 30,0,0,1,0,0,0,ST_IDLE));
        vecs.push_back(mk(0,0,0,0,0,0, 30,0,0,0,0,0,0,ST_IDLE));
        vecs.push_back(mk(0,0,0,1,1,0, 10,1,0,0,0,0,0,ST_VEND));
        vecs.push_back(mk(0,0,0,0,0,1, 10,0,0,0,0,1,2'b10,ST_CHANGE));
        vecs.push_back(mk(0,0,0,0,0,0,  0,0,0,0,0,0,0,ST_CHANGE));
        vecs.push_back(mk(0,0,0,0,0,0,  0,0,0,0,0,0,0,ST_IDLE));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            step(v.rst, v.ser, v.prod, v.buy, v.cret, v.ack);
            check($sformatf("v%0d.credit", i), a_credit, v.credit);
            check($sformatf("v%0d.vend_valid", i), a_vv, v.vv);
            check($sformatf("v%0d.vend_item", i), a_item, v.item);
            check($sformatf("v%0d.error", i), a_err, v.err);
            check($sformatf("v%0d.coin_reject", i), a_rej, v.rej);
            check($sformatf("v%0d.change_valid", i), a_cv, v.cv);
            check($sformatf("v%0d.change_coin", i), a_coin, v.coin);
            check($sformatf("v%0d.state", i), a_st, v.st);
        end

        // Overflow: 190 + 25 refused, 190 + 10 lands exactly on the ceiling
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) send_coin(2'b11, 0, 0);
        send_coin(2'b10, 0, 0);
        send_coin(2'b01, 0, 0);
        check("ovf.credit190", a_credit, 190);
        send_coin(2'b11, 0, 0);
        check("ovf.reject", a_rej, 1);
        check("ovf.credit_kept", a_credit, 190);
        idle();
        check("ovf.reject_one_cycle", a_rej, 0);
        send_coin(2'b10, 0, 0);
        check("ovf.credit200", a_credit, 200);
        check("ovf.dime_accepted", a_rej, 0);

        // Buy on the nickel's completing edge, manual ack to IDLE, then refund
        step(1, 0, 0, 0, 0, 0);
        send_coin(2'b10, 0, 0);
        send_coin(2'b10, 0, 0);
        check("ovl.credit20", m_credit, 20);
        send_coin(2'b01, 1, 0);
        check("ovl.vend_valid", m_vv, 1);
        check("ovl.vend_item", m_item, 0);
        check("ovl.credit5", m_credit, 5);
        step(0, 0, 0, 0, 0, 1);
        check("ovl.ack_clears", m_vv, 0);
        check("ovl.idle_no_auto", m_st, ST_IDLE);
        check("ovl.credit_kept", m_credit, 5);
        exp_q.push_back(2'b01);
        step(0, 0, 0, 0, 1, 0);
        check("ret.state_change", m_st, ST_CHANGE);
        budget = 8;
        while (m_cv && budget > 0) begin
            if (exp_q.size() == 0) check("ret.extra_coin", m_coin, 2'b00);
            else check("ret.coin", m_coin, exp_q.pop_front());
            idle();
            budget--;
        end
        check("ret.drain_in_budget", budget > 0, 1);
        check("ret.coins_left", exp_q.size(), 0);
        check("ret.credit0", m_credit, 0);
        idle();
        check("ret.back_idle", m_st, ST_IDLE);

        // Reset in the middle of change return with a frame starting
        step(1, 0, 0, 0, 0, 0);
        send_coin(2'b11, 0, 0);
        send_coin(2'b11, 0, 0);
        send_coin(2'b10, 0, 0);
        send_coin(2'b01, 0, 0);
        check("rst.credit65", a_credit, 65);
        step(0, 0, 0, 0, 1, 0);
        check("rst.first_coin", a_coin, 2'b11);
        step(0, 1, 0, 0, 0, 0);
        check("rst.credit40", a_credit, 40);
        step(1, 1, 0, 0, 0, 0);
        check("rst.credit0", a_credit, 0);
        check("rst.change_valid", a_cv, 0);
        check("rst.state", a_st, ST_IDLE);
        check("rst.rx_state", a_rx, 0);
        check("rst.vend_valid", a_vv, 0);
        for (int k = 0; k < 3; k++) begin
            idle();
            check($sformatf("rst.frame_gone%0d", k), a_credit, 0);
            check($sformatf("rst.no_reject%0d", k), a_rej, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
